// File: rtl/ps2_scancode_decode.sv
// ps2_scancode_decode
//   Turns the raw PS/2 Set 2 byte stream from ps2_host into whole key events
//   (make/break, normal/extended), including the E0 and F0 prefixes and the
//   8-byte E1 Pause sequence. Events are queued in a show-ahead FIFO that is
//   drained with a valid/ready handshake.
//
//   Optional feature macro: PS2_RESP_FILTER_EN
//     When defined, keyboard response bytes (FA AA EE FE FC 00 FF) that arrive
//     in IDLE are reported on resp_data/resp_valid instead of becoming key
//     events. When undefined, those bytes decode as ordinary make codes and
//     resp_data/resp_valid are tied to 0.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   rx_data    received byte from ps2_host
//   rx_user    byte had a parity/framing error
//   rx_valid   byte available
//   rx_ready   byte accepted (0 in reset, otherwise always 1)
//   key_code   final scancode byte of the head event (0 when empty)
//   key_ext    head event was E0/E1-prefixed
//   key_break  head event is a release
//   key_valid  FIFO head valid
//   key_ready  consumer accepts the head
//   resp_data  keyboard response byte
//   resp_valid one-cycle response strobe
//   err_count  error bytes seen, saturating
//   drop_count events lost to a full FIFO, saturating
module ps2_scancode_decode #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_user,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  output logic [7:0] err_count,
  output logic [7:0] drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, PAUSE} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef PS2_RESP_FILTER_EN
  function automatic logic is_resp(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE) ||
           (b == 8'hFC) || (b == 8'h00) || (b == 8'hFF);
  endfunction
`endif

  state_t      state, state_n;
  logic        ext_f, ext_n;
  logic        brk_f, brk_n;
  logic [2:0]  skip, skip_n;
  logic        rdy_q;
  logic        accept;
  logic        emit;
  logic [9:0]  emit_word;
  logic        err_hit;
`ifdef PS2_RESP_FILTER_EN
  logic        resp_hit;
  logic        resp_vld_p1;
  logic [7:0]  resp_data_p1;
`endif

  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, drop;
  logic [9:0]       head;
  logic [7:0]       err_q, drop_q;

  assign rx_ready = rdy_q;
  assign accept   = rx_valid && rdy_q;

  // Stage 0: decode the accepted byte against the current prefix state
  always_comb begin
    state_n   = state;
    ext_n     = ext_f;
    brk_n     = brk_f;
    skip_n    = skip;
    emit      = 1'b0;
    emit_word = '0;
    err_hit   = 1'b0;
`ifdef PS2_RESP_FILTER_EN
    resp_hit  = 1'b0;
`endif
    if (accept) begin
      if (rx_user) begin
        // A corrupted byte poisons whatever prefix sequence was in flight.
        err_hit = 1'b1;
        state_n = IDLE;
        ext_n   = 1'b0;
        brk_n   = 1'b0;
        skip_n  = '0;
      end else if (state == PAUSE) begin
        // Pause has no break code; the 7 bytes after E1 are swallowed whole.
        if (skip == 3'd1) begin
          emit      = 1'b1;
          emit_word = {1'b1, 1'b0, 8'hE1};
          state_n   = IDLE;
          skip_n    = '0;
        end else begin
          skip_n = skip - 3'd1;
        end
      end else if (state == IDLE && rx_data == 8'hE0) begin
        state_n = EXT;
        ext_n   = 1'b1;
      end else if ((state == IDLE || state == EXT) && rx_data == 8'hF0) begin
        state_n = BRK;
        brk_n   = 1'b1;
      end else if (state == IDLE && rx_data == 8'hE1) begin
        state_n = PAUSE;
        skip_n  = 3'd7;
`ifdef PS2_RESP_FILTER_EN
      end else if (state == IDLE && is_resp(rx_data)) begin
        resp_hit = 1'b1;
`endif
      end else begin
        emit      = 1'b1;
        emit_word = {ext_f, brk_f, rx_data};
        state_n   = IDLE;
        ext_n     = 1'b0;
        brk_n     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ext_f <= 1'b0;
      brk_f <= 1'b0;
      skip  <= '0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      ext_f <= ext_n;
      brk_f <= brk_n;
      skip  <= skip_n;
      rdy_q <= 1'b1;
    end
  end

  // Stage 1: event FIFO, counters and response strobe
  assign key_valid = (count != '0);
  assign pop       = key_valid && key_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push      = emit && ((count < DEPTH_C) || pop);
  assign drop      = emit && !push;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= emit_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (err_hit) err_q  <= sat_inc8(err_q);
      if (drop)    drop_q <= sat_inc8(drop_q);
    end
  end

  // Head fields read as zero while empty so the outputs never show stale RAM.
  assign head       = key_valid ? mem[rd_ptr] : 10'd0;
  assign key_ext    = head[9];
  assign key_break  = head[8];
  assign key_code   = head[7:0];
  assign err_count  = err_q;
  assign drop_count = drop_q;

`ifdef PS2_RESP_FILTER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_vld_p1  <= 1'b0;
      resp_data_p1 <= '0;
    end else begin
      resp_vld_p1 <= resp_hit;
      if (resp_hit) resp_data_p1 <= rx_data;
    end
  end
  assign resp_valid = resp_vld_p1;
  assign resp_data  = resp_data_p1;
`else
  assign resp_valid = 1'b0;
  assign resp_data  = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decode.sv
// Directed bench for ps2_scancode_decode: prefix decoding, Pause, error
// recovery, FIFO overflow/drain, response filter and mid-sequence reset.
module tb_ps2_scancode_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_user;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic [7:0] err_count;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  ps2_scancode_decode #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_user    (rx_user),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .err_count  (err_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] head();
    return 32'({key_ext, key_break, key_code});
  endfunction

  // One byte presented for exactly one cycle; returns at the negedge after
  // the accepting edge, i.e. in the cycle where results become visible.
  task automatic send(input logic [7:0] b, input logic u);
    @(negedge clk);
    rx_data  = b;
    rx_user  = u;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_user  = 1'b0;
  endtask

  task automatic pop1();
    @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    rx_data   = 8'h00;
    rx_user   = 1'b0;
    rx_valid  = 1'b0;
    key_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_head", head(), 32'h000);
    chk("rst_err", 32'(err_count), 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_data", 32'(resp_data), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_rst", 32'(rx_ready), 32'h1);

    // Single make
    send(8'h1C, 1'b0);
    chk("make_valid", 32'(key_valid), 32'h1);
    chk("make_head", head(), 32'h01C);
    pop1();
    chk("make_popped", 32'(key_valid), 32'h0);

    // Break, extended make, extended break
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    chk("seq_head0", head(), 32'h11C);
    pop1();
    chk("seq_head1", head(), 32'h275);
    pop1();
    chk("seq_head2", head(), 32'h375);
    pop1();
    chk("seq_empty", 32'(key_valid), 32'h0);

    // Pause sequence: one event only after the 8th byte
    send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
    send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0);
    chk("pause_not_yet", 32'(key_valid), 32'h0);
    send(8'h77, 1'b0);
    chk("pause_head", head(), 32'h2E1);
    pop1();
    chk("pause_single", 32'(key_valid), 32'h0);
    send(8'h1C, 1'b0);
    chk("after_pause", head(), 32'h01C);
    pop1();

    // Error byte after E0 drops the prefix
    send(8'hE0, 1'b0);
    send(8'h1C, 1'b1);
    chk("err_count1", 32'(err_count), 32'h1);
    chk("err_no_event", 32'(key_valid), 32'h0);
    send(8'h1C, 1'b0);
    chk("err_no_ext", head(), 32'h01C);
    pop1();
    chk("err_drained", 32'(key_valid), 32'h0);

    // Overflow: 9 makes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
    chk("ovf_drop", 32'(drop_count), 32'h1);
    chk("ovf_head", head(), 32'h001);
    // Push and pop in the same cycle while full
    @(negedge clk);
    rx_data   = 8'h0A;
    rx_valid  = 1'b1;
    key_ready = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    key_ready = 1'b0;
    chk("full_pushpop_drop", 32'(drop_count), 32'h1);
    for (int i = 2; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), head(), 32'(i));
      pop1();
    end
    chk("drain_last", head(), 32'h00A);
    pop1();
    chk("drain_empty", 32'(key_valid), 32'h0);

    // Keyboard response byte
    send(8'hFA, 1'b0);
`ifdef PS2_RESP_FILTER_EN
    chk("resp_valid", 32'(resp_valid), 32'h1);
    chk("resp_data", 32'(resp_data), 32'hFA);
    chk("resp_no_key", 32'(key_valid), 32'h0);
    @(negedge clk);
    chk("resp_pulse_end", 32'(resp_valid), 32'h0);
`else
    chk("fa_as_key", head(), 32'h0FA);
    chk("fa_no_resp", 32'(resp_valid), 32'h0);
    pop1();
`endif

    // Reset with data queued and a prefix pending
    send(8'h33, 1'b0);
    send(8'hE0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(key_valid), 32'h0);
    chk("mid_rst_err", 32'(err_count), 32'h0);
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    send(8'h1C, 1'b0);
    chk("post_rst_head", head(), 32'h01C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
